cnn_conv_engine: RTL and testbench



---
 rtl/cnn_pkg.sv | 33 +++
 rtl/cnn_window_buf.sv | 60 ++++++
 rtl/cnn_conv_engine.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_cnn_conv_engine.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the streaming 3x3 convolution engine: register map,
// FSM state encoding and address helpers.
package cnn_pkg;

    localparam logic [7:0]  REG_CTRL           = 8'h00;
    localparam logic [7:0]  REG_STATUS         = 8'h04;
    localparam logic [7:0]  REG_WIN_CNT        = 8'h08;
    localparam logic [7:0]  REG_SHIFT          = 8'h0C;
    localparam int          REG_BIAS_BASE      = 32'h20;
    localparam int          REG_WEIGHT_BASE    = 32'h40;
    localparam int          WEIGHT_STRIDE      = 32'h24;
    localparam int          WIN_TAPS           = 9;
    localparam int          MAX_CH             = 8;
    localparam logic [31:0] ADDR_UNMAPPED_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        MAC    = 3'd2,
        OUT    = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Nine bits so that every channel's weight block decodes without aliasing.
    function automatic logic [8:0] bias_addr(input int c);
        return 9'(REG_BIAS_BASE + 4 * c);
    endfunction

    function automatic logic [8:0] weight_addr(input int c, input int k);
        return 9'(REG_WEIGHT_BASE + WEIGHT_STRIDE * c + 4 * k);
    endfunction

endpackage

// File: rtl/cnn_window_buf.sv
// Sliding 3x3 window over a raster pixel stream: two line delays of IMG_W
// pixels feed a 3x3 shift register; window_o is row-major, index 8 = newest.
module cnn_window_buf
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       shift_i,
    input  logic [DATA_WIDTH-1:0]      pix_i,
    output logic [8:0][DATA_WIDTH-1:0] window_o
);

    logic [DATA_WIDTH-1:0] line0_q [IMG_W];
    logic [DATA_WIDTH-1:0] line1_q [IMG_W];
    logic [DATA_WIDTH-1:0] win_q   [3][3];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < IMG_W; i++) begin
                line0_q[i] <= '0;
                line1_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (shift_i) begin
            line0_q[0] <= pix_i;
            line1_q[0] <= line0_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                line0_q[i] <= line0_q[i-1];
                line1_q[i] <= line1_q[i-1];
            end
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            // Line outputs hold the same column from one and two rows above.
            win_q[0][2] <= line1_q[IMG_W-1];
            win_q[1][2] <= line0_q[IMG_W-1];
            win_q[2][2] <= pix_i;
        end else begin
            win_q <= win_q;
        end
    end

    always_comb begin
        window_o = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window_o[3*r+c] = win_q[r][c];
            end
        end
    end

endmodule

// File: rtl/cnn_conv_engine.sv
// Register-configured 3x3 convolution engine with NUM_CH output channels,
// per-channel bias, optional ReLU and a sequential MAC.
// Optional output scaling/saturation is enabled by defining CNN_OUT_SAT_EN.
module cnn_conv_engine
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int NUM_CH     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [7:0]            addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    input  logic [DATA_WIDTH-1:0] pix_data_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [ACC_WIDTH-1:0]  res_data_o,
    output logic [2:0]            res_ch_o,
    output logic                  done_o
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW = 2 * DATA_WIDTH + 1;

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [2:0]             ch_q, ch_d;
    logic [3:0]             k_q, k_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   last_q, last_d;
    logic [31:0]            win_cnt_q, win_cnt_d;
    logic                   relu_q, relu_d;
    logic                   done_q, done_d;
    logic                   rvalid_q;
    logic [31:0]            rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]  weight_q [MAX_CH][WIN_TAPS];
    logic [ACC_WIDTH-1:0]   bias_q   [MAX_CH];

    logic                        wr_s, rd_s, start_s, busy_s, shift_win_s;
    logic [MAX_CH-1:0]           bias_hit_s;
    logic [MAX_CH-1:0][8:0]      w_hit_s;
    logic                        map_hit_s;
    logic [31:0]                 map_data_s, reg_data_s;
    logic [8:0][DATA_WIDTH-1:0]  win_s;
    logic [PW-1:0]               w_ext_s, p_ext_s, prod_s;
    logic signed [ACC_WIDTH-1:0] relu_s, res_s;

`ifdef CNN_OUT_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    logic [4:0]                  shift_q, shift_d;
    logic signed [ACC_WIDTH-1:0] shifted_s;
`endif

    assign wr_s    = req_i & we_i;
    assign rd_s    = req_i & ~we_i;
    assign start_s = wr_s && (addr_i == REG_CTRL) && wdata_i[0];
    assign busy_s  = (state_q != IDLE);

    cnn_window_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_W      (IMG_W)
    ) u_window_buf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .shift_i  (shift_win_s),
        .pix_i    (pix_data_i),
        .window_o (win_s)
    );

    // Address decode for the per-channel bias and weight banks.
    always_comb begin
        bias_hit_s = '0;
        w_hit_s    = '0;
        map_hit_s  = 1'b0;
        map_data_s = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            bias_hit_s[c] = ({1'b0, addr_i} == bias_addr(c));
            map_data_s    = map_data_s | (bias_hit_s[c] ? 32'($signed(bias_q[c])) : 32'd0);
            for (int k = 0; k < WIN_TAPS; k++) begin
                w_hit_s[c][k] = ({1'b0, addr_i} == weight_addr(c, k));
                map_data_s    = map_data_s | (w_hit_s[c][k] ?
                    {{(32-DATA_WIDTH){weight_q[c][k][DATA_WIDTH-1]}}, weight_q[c][k]} : 32'd0);
            end
        end
        map_hit_s = (|bias_hit_s) | (|w_hit_s);
    end

    // Read mux for the fixed control/status registers.
    always_comb begin
        case (addr_i)
            REG_CTRL:    reg_data_s = {30'd0, relu_q, 1'b0};
            REG_STATUS:  reg_data_s = {30'd0, done_q | (state_q == DONE), busy_s};
            REG_WIN_CNT: reg_data_s = win_cnt_q;
`ifdef CNN_OUT_SAT_EN
            REG_SHIFT:   reg_data_s = {27'd0, shift_q};
`endif
            default:     reg_data_s = ADDR_UNMAPPED_DATA;
        endcase
        rdata_d = map_hit_s ? map_data_s : reg_data_s;
    end

    // Next values for control bits; a STATUS read wins over a same-cycle done.
    always_comb begin
        relu_d = relu_q;
        done_d = done_q;
        if (wr_s && (addr_i == REG_CTRL)) begin
            relu_d = wdata_i[1];
        end else begin
            relu_d = relu_q;
        end
        if (rd_s && (addr_i == REG_STATUS)) begin
            done_d = 1'b0;
        end else if (state_q == DONE) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end
`ifdef CNN_OUT_SAT_EN
        if (wr_s && (addr_i == REG_SHIFT)) begin
            shift_d = wdata_i[4:0];
        end else begin
            shift_d = shift_q;
        end
`endif
    end

    // Configuration registers and bus response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            relu_q   <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
`ifdef CNN_OUT_SAT_EN
            shift_q  <= 5'd0;
`endif
            for (int c = 0; c < MAX_CH; c++) begin
                bias_q[c] <= '0;
                for (int k = 0; k < WIN_TAPS; k++) begin
                    weight_q[c][k] <= '0;
                end
            end
        end else begin
            relu_q   <= relu_d;
            done_q   <= done_d;
            rvalid_q <= req_i;
            rdata_q  <= rd_s ? rdata_d : 32'd0;
`ifdef CNN_OUT_SAT_EN
            shift_q  <= shift_d;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_s && !busy_s && bias_hit_s[c]) begin
                    bias_q[c] <= ACC_WIDTH'($signed(wdata_i));
                end
                for (int k = 0; k < WIN_TAPS; k++) begin
                    if (wr_s && !busy_s && w_hit_s[c][k]) begin
                        weight_q[c][k] <= wdata_i[DATA_WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Signed weight times zero-extended pixel; the low PW bits are exact.
    assign w_ext_s = {{(DATA_WIDTH+1){weight_q[ch_q][k_q][DATA_WIDTH-1]}}, weight_q[ch_q][k_q]};
    assign p_ext_s = {{(DATA_WIDTH+1){1'b0}}, win_s[k_q]};
    assign prod_s  = w_ext_s * p_ext_s;

    // Frame sequencing: stream pixels, MAC each channel, present results.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        ch_d        = ch_q;
        k_d         = k_q;
        acc_d       = acc_q;
        last_d      = last_q;
        win_cnt_d   = win_cnt_q;
        shift_win_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d   = STREAM;
                    col_d     = '0;
                    row_d     = '0;
                    win_cnt_d = 32'd0;
                    last_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (pix_valid_i) begin
                    shift_win_s = 1'b1;
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
                        state_d = MAC;
                        ch_d    = 3'd0;
                        k_d     = 4'd0;
                        acc_d   = bias_q[0];
                        last_d  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            MAC: begin
                acc_d = acc_q + {{(ACC_WIDTH-PW){prod_s[PW-1]}}, prod_s};
                if (k_q == 4'd8) begin
                    k_d     = 4'd0;
                    state_d = OUT;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    if (32'(ch_q) < NUM_CH - 1) begin
                        ch_d    = ch_q + 3'd1;
                        k_d     = 4'd0;
                        acc_d   = bias_q[ch_q + 3'd1];
                        state_d = MAC;
                    end else begin
                        win_cnt_d = win_cnt_q + 32'd1;
                        state_d   = last_q ? DONE : STREAM;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and FSM state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            ch_q      <= 3'd0;
            k_q       <= 4'd0;
            acc_q     <= '0;
            last_q    <= 1'b0;
            win_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            ch_q      <= ch_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            last_q    <= last_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    // Result shaping: ReLU first, then optional arithmetic shift and clamp.
    always_comb begin
        if (relu_q && acc_q[ACC_WIDTH-1]) begin
            relu_s = '0;
        end else begin
            relu_s = acc_q;
        end
`ifdef CNN_OUT_SAT_EN
        shifted_s = relu_s >>> shift_q;
        if (shifted_s > SAT_MAX) begin
            res_s = SAT_MAX;
        end else if (shifted_s < SAT_MIN) begin
            res_s = SAT_MIN;
        end else begin
            res_s = shifted_s;
        end
`else
        res_s = relu_s;
`endif
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign pix_ready_o = (state_q == STREAM);
    assign res_valid_o = (state_q == OUT);
    assign res_data_o  = (state_q == OUT) ? res_s : '0;
    assign res_ch_o    = (state_q == OUT) ? ch_q : 3'd0;
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Directed self-checking bench for cnn_conv_engine on a 4x4 image, 2 channels.
// Also exercises the scaled/saturated output when CNN_OUT_SAT_EN is defined.
module tb_cnn_conv_engine;

    logic        clk = 1'b0;
    logic        rst_i, req_i, we_i, pix_valid_i, res_ready_i;
    logic [7:0]  addr_i, pix_data_i;
    logic [31:0] wdata_i, rdata_o, res_data_o;
    logic        gnt_o, rvalid_o, pix_ready_o, res_valid_o, done_o;
    logic [2:0]  res_ch_o;

    logic [7:0]  pix_a [16];
    logic [31:0] res_d_a [32];
    logic [2:0]  res_c_a [32];
    logic [31:0] exp_conv [8] = '{32'd6, 32'd44, 32'd7, 32'd53, 32'd10, 32'd80, 32'd11, 32'd89};
    int n_res, n_done, lat, n_pass, n_chk;

    always #5 clk = ~clk;

    cnn_conv_engine #(
        .DATA_WIDTH(8), .ACC_WIDTH(32), .IMG_W(4), .IMG_H(4), .NUM_CH(2)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o), .pix_data_i(pix_data_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_ch_o(res_ch_o), .done_o(done_o)
    );

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(posedge clk); #1;
        req_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic run_frame(input int hold, input logic [31:0] hold_exp, input bit poke);
        int pi = 0, cyc = 0, stall = 0, post = -1, t_win = -1, t_first = -1;
        bit fire;
        n_res = 0; n_done = 0;
        while (cyc < 600 && post != 0) begin
            pix_valid_i = (pi < 16);
            pix_data_i  = pix_a[pi & 15];
            if (res_valid_o && n_res == 0 && stall < hold) begin
                res_ready_i = 1'b0;
                stall++;
                n_chk++;
                if ({res_valid_o, pix_ready_o, res_data_o} !== {1'b1, 1'b0, hold_exp}) begin
                    $display("FAIL stall_hold: got valid=%0b ready=%0b data=%0d, expected valid=1 ready=0 data=%0d",
                             res_valid_o, pix_ready_o, res_data_o, hold_exp);
                end else n_pass++;
            end else begin
                res_ready_i = 1'b1;
            end
            if (poke) begin
                if (cyc == 3) begin
                    req_i = 1'b1; we_i = 1'b1; addr_i = 8'h00; wdata_i = 32'd1;
                end else if (cyc == 4) begin
                    addr_i = 8'h40; wdata_i = 32'd5;
                end else begin
                    req_i = 1'b0; we_i = 1'b0;
                end
            end
            if (res_valid_o && t_first < 0) t_first = cyc;
            if (pix_valid_i && pix_ready_o && pi == 10) t_win = cyc;
            if (res_valid_o && res_ready_i) begin
                if (n_res < 32) begin
                    res_d_a[n_res] = res_data_o;
                    res_c_a[n_res] = res_ch_o;
                end
                n_res++;
            end
            if (done_o) begin
                n_done++;
                post = 4;
            end
            fire = pix_valid_i && pix_ready_o;
            @(posedge clk); #1;
            if (fire) pi++;
            if (post > 0) post--;
            cyc++;
        end
        pix_valid_i = 1'b0; res_ready_i = 1'b0;
        lat = t_first - t_win;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 8'd0; wdata_i = 32'd0;
        pix_valid_i = 1'b0; pix_data_i = 8'd0; res_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        n_chk++;
        if ({gnt_o, rvalid_o, rdata_o, pix_ready_o, res_valid_o, res_data_o, res_ch_o, done_o} !== 71'd0) begin
            $display("FAIL reset_outputs: got rvalid=%0b rdata=%h pix_ready=%0b res_valid=%0b res_data=%h ch=%0d done=%0b, expected all 0",
                     rvalid_o, rdata_o, pix_ready_o, res_valid_o, res_data_o, res_ch_o, done_o);
        end else n_pass++;
        bus_read(8'h44, d);
        n_chk++;
        if (d !== 32'd0) $display("FAIL reset_weight: got %h expected 00000000", d);
        else n_pass++;
    endtask

    task automatic test_regs;
        logic [31:0] d;
        bus_read(8'h3C, d);
        n_chk++;
        if (d !== 32'hDEAD_BEEF || rvalid_o !== 1'b1) $display("FAIL unmapped_read: got %h rvalid=%0b expected deadbeef rvalid=1", d, rvalid_o);
        else n_pass++;
        bus_write(8'h44, 32'h0000_00FE);
        bus_read(8'h44, d);
        n_chk++;
        if (d !== 32'hFFFF_FFFE) $display("FAIL weight_sext: got %h expected fffffffe", d);
        else n_pass++;
        bus_write(8'h44, 32'd0);
        bus_read(8'h08, d);
        n_chk++;
        if (d !== 32'd0) $display("FAIL win_cnt_reset: got %h expected 0", d);
        else n_pass++;
    endtask

    task automatic test_conv;
        logic [31:0] d;
        for (int k = 0; k < 9; k++) begin
            bus_write(8'(8'h40 + 4 * k), (k == 4) ? 32'd1 : 32'd0);
            bus_write(8'(8'h64 + 4 * k), 32'd1);
        end
        bus_write(8'h20, 32'd0);
        bus_write(8'h24, 32'hFFFF_FFF6);
        bus_read(8'h24, d);
        n_chk++;
        if (d !== 32'hFFFF_FFF6) $display("FAIL bias_readback: got %h expected fffffff6", d);
        else n_pass++;
        for (int i = 0; i < 16; i++) pix_a[i] = 8'(i + 1);
        bus_write(8'h00, 32'd1);
        run_frame(0, 32'd0, 1'b0);
        n_chk++;
        if (n_res !== 8) $display("FAIL conv_count: got %0d expected 8", n_res);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (res_d_a[i] !== exp_conv[i] || res_c_a[i] !== 3'(i % 2))
                $display("FAIL conv_result[%0d]: got data=%0d ch=%0d expected data=%0d ch=%0d",
                         i, res_d_a[i], res_c_a[i], exp_conv[i], i % 2);
            else n_pass++;
        end
        n_chk++;
        if (n_done !== 1) $display("FAIL conv_done: got %0d pulses expected 1", n_done);
        else n_pass++;
        n_chk++;
        if (lat !== 10) $display("FAIL conv_latency: got %0d cycles expected 10", lat);
        else n_pass++;
        bus_read(8'h08, d);
        n_chk++;
        if (d !== 32'd4) $display("FAIL win_cnt: got %0d expected 4", d);
        else n_pass++;
        bus_read(8'h04, d);
        n_chk++;
        if (d !== 32'd2) $display("FAIL status_done: got %h expected 2", d);
        else n_pass++;
        bus_read(8'h04, d);
        n_chk++;
        if (d !== 32'd0) $display("FAIL status_clear: got %h expected 0", d);
        else n_pass++;
    endtask

    task automatic test_relu;
        logic [31:0] d;
        bus_write(8'h24, 32'hFFFF_FF9C);
        bus_write(8'h00, 32'd1);
        run_frame(0, 32'd0, 1'b0);
        n_chk++;
        if (res_d_a[1] !== 32'hFFFF_FFD2 || res_d_a[0] !== 32'd6)
            $display("FAIL relu_off: got ch0=%h ch1=%h expected 00000006 ffffffd2", res_d_a[0], res_d_a[1]);
        else n_pass++;
        bus_write(8'h00, 32'd3);
        run_frame(0, 32'd0, 1'b0);
        n_chk++;
        if (res_d_a[1] !== 32'd0 || res_d_a[3] !== 32'd0 || res_d_a[0] !== 32'd6)
            $display("FAIL relu_on: got ch0=%h ch1=%h ch1b=%h expected 6 0 0", res_d_a[0], res_d_a[1], res_d_a[3]);
        else n_pass++;
        bus_read(8'h00, d);
        n_chk++;
        if (d !== 32'd2) $display("FAIL ctrl_read: got %h expected 2", d);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        bus_write(8'h24, 32'hFFFF_FFF6);
        bus_write(8'h00, 32'd1);
        run_frame(5, 32'd6, 1'b0);
        n_chk++;
        if (n_res !== 8 || n_done !== 1) $display("FAIL bp_count: got %0d results %0d done expected 8 1", n_res, n_done);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (res_d_a[i] !== exp_conv[i]) $display("FAIL bp_result[%0d]: got %0d expected %0d", i, res_d_a[i], exp_conv[i]);
            else n_pass++;
        end
    endtask

    task automatic test_busy;
        logic [31:0] d;
        bus_write(8'h00, 32'd1);
        run_frame(0, 32'd0, 1'b1);
        n_chk++;
        if (n_res !== 8 || n_done !== 1) $display("FAIL busy_count: got %0d results %0d done expected 8 1", n_res, n_done);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (res_d_a[i] !== exp_conv[i]) $display("FAIL busy_result[%0d]: got %0d expected %0d", i, res_d_a[i], exp_conv[i]);
            else n_pass++;
        end
        bus_read(8'h40, d);
        n_chk++;
        if (d !== 32'd0) $display("FAIL busy_weight_write: got %h expected 0", d);
        else n_pass++;
    endtask

`ifdef CNN_OUT_SAT_EN
    task automatic test_sat;
        logic [31:0] d;
        for (int k = 0; k < 9; k++) bus_write(8'(8'h64 + 4 * k), 32'd127);
        bus_write(8'h24, 32'd0);
        bus_write(8'h0C, 32'd2);
        bus_read(8'h0C, d);
        n_chk++;
        if (d !== 32'd2) $display("FAIL shift_read: got %h expected 2", d);
        else n_pass++;
        for (int i = 0; i < 16; i++) pix_a[i] = 8'd255;
        bus_write(8'h00, 32'd1);
        run_frame(0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (res_d_a[2*i] !== 32'd63 || res_d_a[2*i+1] !== 32'd127)
                $display("FAIL sat_result[%0d]: got ch0=%0d ch1=%0d expected 63 127", i, res_d_a[2*i], res_d_a[2*i+1]);
            else n_pass++;
        end
        bus_write(8'h0C, 32'd0);
    endtask
`endif

    task automatic test_reset_midframe;
        logic [31:0] d;
        int dn = 0;
        for (int i = 0; i < 16; i++) pix_a[i] = 8'(i + 1);
        bus_write(8'h00, 32'd1);
        pix_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pix_data_i = pix_a[i];
            @(posedge clk); #1;
        end
        pix_valid_i = 1'b0;
        n_chk++;
        if (pix_ready_o !== 1'b0) $display("FAIL midframe_mac: got pix_ready=%0b expected 0", pix_ready_o);
        else n_pass++;
        rst_i = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({rvalid_o, rdata_o, pix_ready_o, res_valid_o, res_data_o, res_ch_o, done_o} !== 70'd0)
            $display("FAIL midframe_reset_outputs: got pix_ready=%0b res_valid=%0b res_data=%h done=%0b expected all 0",
                     pix_ready_o, res_valid_o, res_data_o, done_o);
        else n_pass++;
        rst_i = 1'b0;
        res_ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done_o) dn++;
            @(posedge clk); #1;
        end
        res_ready_i = 1'b0;
        n_chk++;
        if (dn !== 0) $display("FAIL midframe_no_done: got %0d pulses expected 0", dn);
        else n_pass++;
        bus_read(8'h04, d);
        n_chk++;
        if (d !== 32'd0) $display("FAIL midframe_status: got %h expected 0", d);
        else n_pass++;
        bus_read(8'h64, d);
        n_chk++;
        if (d !== 32'd0) $display("FAIL midframe_weight_clear: got %h expected 0", d);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_chk = 0;
        test_reset;
        test_regs;
        test_conv;
        test_relu;
        test_backpressure;
        test_busy;
`ifdef CNN_OUT_SAT_EN
        test_sat;
`endif
        test_reset_midframe;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
